keypad_encoder: RTL
===================

KEYPAD_ENCODER -- requirements
Module: keypad_encoder

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, 16, number of consecutive CLK cycles a synchronized key code must hold before it is accepted (range 1..255).
REQ-002 CLK  input  1  system clock, rising-edge active.
REQ-003 clearn  input  1  reset, asynchronous and active-low.
REQ-004 keypad  input  10  raw key lines, active-high, bit k = key "k" (0..9), asynchronous to CLK.
REQ-005 enablen  input  1  active-low entry enable from the controller; high blocks acceptance of new keys.
REQ-006 digit  output  4  BCD value of the last accepted key, fed to the timer digit input.
REQ-007 loadn  output  1  active-low load strobe to the timer, low for exactly one CLK cycle per accepted key.
REQ-008 key_err  output  1  high while more than one key line is asserted after synchronization.

Function
REQ-009 keypad SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized vector only.
REQ-010 A synchronized vector with exactly one bit set SHALL be "valid"; its bit index SHALL be the code; all-zero SHALL be "released"; two or more bits set SHALL be "invalid".
REQ-011 FSM states: IDLE, DEBOUNCE, LOAD, WAIT_RELEASE.
REQ-012 IDLE -> DEBOUNCE when vector valid and enablen low; the code is captured and the cycle counter cleared.
REQ-013 DEBOUNCE: counter increments each cycle the vector equals the captured one-hot; any change -> IDLE; counter reaching DEBOUNCE_CYCLES -> LOAD.
REQ-014 LOAD: lasts one cycle; digit SHALL update to the captured code on entry; loadn SHALL be low during this cycle only; next state WAIT_RELEASE.
REQ-015 WAIT_RELEASE: returns to IDLE only after the vector is released for DEBOUNCE_CYCLES consecutive cycles; any non-zero vector restarts the count; a held key SHALL never produce a second strobe.
REQ-016 digit SHALL hold its value between strobes; loadn SHALL be registered (glitch-free).
REQ-017 enablen going high in DEBOUNCE SHALL abort to IDLE without a strobe; in LOAD the strobe SHALL complete.
REQ-018 key_err SHALL be registered, high one cycle after an invalid vector appears, and low one cycle after it clears; an invalid vector in DEBOUNCE -> IDLE.
REQ-019 The counter SHALL be 8 bits wide and SHALL saturate, never wrap.

Reset
REQ-020 clearn low SHALL immediately force: state IDLE, digit 4'd0, loadn 1, key_err 0, counter 0, synchronizer flops 0.
REQ-021 Reset during DEBOUNCE or LOAD SHALL suppress any pending or in-progress strobe; after release, a key still held SHALL be re-debounced from IDLE.

Configuration
REQ-022 Macro KEYPAD_DEBOUNCE_EN: when defined, REQ-013 and REQ-015 apply as written.
REQ-023 When undefined, DEBOUNCE and WAIT_RELEASE SHALL each use a count of 1 cycle regardless of DEBOUNCE_CYCLES (simulation-speed build), and all other behaviour is unchanged.

Structure
REQ-024 A shared package SHALL hold the FSM state encoding (2-bit constants) and the one-hot-to-BCD table constants.
REQ-025 The synchronizer plus valid/released/invalid classification SHALL be one sub-module, keypad_sync.
REQ-026 The FSM, counter and output registers SHALL live in keypad_encoder.

Verification
REQ-027 DEBOUNCE_CYCLES=4, hold key 7 for 20 cycles -> exactly one loadn low pulse, digit=4'd7; no further pulse until release.
REQ-028 Key 3 chatters (toggles every 2 cycles) for 12 cycles, then holds -> no strobe during chatter; one strobe after stable hold; digit=4'd3.
REQ-029 Keys 2 and 5 pressed together -> key_err=1, no strobe, digit unchanged; release 5 while 2 is held -> key_err=0, then one strobe with digit=4'd2.
REQ-030 Enter 1,2,0 with release between each -> three strobes, digit sequence 1,2,0, each loadn low exactly 1 cycle.
REQ-031 enablen=1, press key 9 -> no strobe; clearn pulsed low mid-DEBOUNCE -> outputs at reset values, no strobe.
REQ-032 Build without KEYPAD_DEBOUNCE_EN, press key 4 -> strobe 3 cycles after the key is sampled (2 synchronizer cycles plus 1 debounce cycle), digit=4'd4.

Source files
------------

// File: rtl/keypad_encoder_pkg.sv
// -----------------------------------------------------------------------------
// keypad_encoder_pkg
// Shared definitions for the keypad encoder slice:
//   - 2-bit FSM state encoding used by keypad_encoder
//   - one-hot key index to BCD table and the helpers built on it
//   - saturating 8-bit increment used by the debounce/release counter
// No ports (package).
// -----------------------------------------------------------------------------
package keypad_encoder_pkg;

    localparam int unsigned NUM_KEYS = 10;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_DEBOUNCE     = 2'd1,
        ST_LOAD         = 2'd2,
        ST_WAIT_RELEASE = 2'd3
    } kp_state_e;

    // BCD value presented for each key line index.
    localparam logic [3:0] KEY_BCD [NUM_KEYS] = '{
        4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9
    };

    // OR of the table entries selected by the vector; exact for one-hot input.
    function automatic logic [3:0] onehot_to_bcd(input logic [NUM_KEYS-1:0] vec);
        logic [3:0] bcd;
        bcd = 4'd0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            bcd = bcd | (KEY_BCD[k] & {4{vec[k]}});
        end
        return bcd;
    endfunction

    // Number of asserted key lines (at most 10, fits in 4 bits).
    function automatic logic [3:0] count_ones(input logic [NUM_KEYS-1:0] vec);
        logic [3:0] sum;
        sum = 4'd0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            sum = sum + {3'd0, vec[k]};
        end
        return sum;
    endfunction

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        return (value == 8'hFF) ? value : (value + 8'd1);
    endfunction

endpackage

// File: rtl/keypad_sync.sv
// -----------------------------------------------------------------------------
// keypad_sync
// Brings the asynchronous key lines into the CLK domain through a two-flop
// synchronizer and classifies the synchronized vector.
// Ports:
//   CLK          in   system clock, rising edge
//   clearn       in   asynchronous active-low reset
//   keypad[9:0]  in   raw active-high key lines (asynchronous)
//   key_vec      out  synchronized key vector (registered)
//   key_valid    out  exactly one line set
//   key_released out  no line set
//   key_invalid  out  two or more lines set
//   key_code     out  BCD index of the set line (meaningful when key_valid)
// -----------------------------------------------------------------------------
module keypad_sync
    import keypad_encoder_pkg::*;
(
    input  logic                CLK,
    input  logic                clearn,
    input  logic [NUM_KEYS-1:0] keypad,
    output logic [NUM_KEYS-1:0] key_vec,
    output logic                key_valid,
    output logic                key_released,
    output logic                key_invalid,
    output logic [3:0]          key_code
);

    logic [NUM_KEYS-1:0] meta_r;
    logic [NUM_KEYS-1:0] sync_r;
    logic [3:0]          ones_s;

    // Two-flop synchronizer; only sync_r is allowed to feed decisions.
    always_ff @(posedge CLK or negedge clearn) begin
        if (!clearn) begin
            meta_r <= {NUM_KEYS{1'b0}};
            sync_r <= {NUM_KEYS{1'b0}};
        end else begin
            meta_r <= keypad;
            sync_r <= meta_r;
        end
    end

    // Classify the synchronized vector by how many lines are set.
    always_comb begin
        ones_s       = count_ones(sync_r);
        key_valid    = (ones_s == 4'd1);
        key_released = (ones_s == 4'd0);
        key_invalid  = (ones_s > 4'd1);
        key_code     = onehot_to_bcd(sync_r);
    end

    assign key_vec = sync_r;

endmodule

// File: rtl/keypad_encoder.sv
// -----------------------------------------------------------------------------
// keypad_encoder
// Debounces a 10-key keypad and hands each accepted key to the timer as a BCD
// digit with a one-cycle active-low load strobe.
// Ports:
//   CLK          in   system clock, rising edge
//   clearn       in   asynchronous active-low reset
//   keypad[9:0]  in   raw active-high key lines (asynchronous)
//   enablen      in   active-low entry enable; high blocks new keys
//   digit[3:0]   out  BCD of the last accepted key (held between strobes)
//   loadn        out  active-low load strobe, one cycle per accepted key
//   key_err      out  high while more than one synchronized line is set
// Parameter:
//   DEBOUNCE_CYCLES  stable cycles required to accept a key / a release (1..255)
// Build option:
//   KEYPAD_DEBOUNCE_EN  when defined, DEBOUNCE_CYCLES is honoured; otherwise
//                       the press and release filters each take one cycle so
//                       simulations run quickly.
// -----------------------------------------------------------------------------
module keypad_encoder
    import keypad_encoder_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic                CLK,
    input  logic                clearn,
    input  logic [NUM_KEYS-1:0] keypad,
    input  logic                enablen,
    output logic [3:0]          digit,
    output logic                loadn,
    output logic                key_err
);

    // Out-of-range settings are clamped into 1..255 so the counter can reach them.
    localparam logic [7:0] DB_CFG = (DEBOUNCE_CYCLES < 32'd1)   ? 8'd1   :
                                    (DEBOUNCE_CYCLES > 32'd255) ? 8'd255 :
                                    8'(DEBOUNCE_CYCLES);
`ifdef KEYPAD_DEBOUNCE_EN
    localparam logic [7:0] DB_COUNT = DB_CFG;
`else
    // Fast build: both filters capped at a single cycle.
    localparam logic [7:0] DB_COUNT = (DB_CFG > 8'd1) ? 8'd1 : DB_CFG;
`endif

    logic [NUM_KEYS-1:0] key_vec_s;
    logic                key_valid_s;
    logic                key_released_s;
    logic                key_invalid_s;
    logic [3:0]          key_code_s;

    kp_state_e           state_r;
    logic [7:0]          cnt_r;
    logic [NUM_KEYS-1:0] onehot_r;
    logic [3:0]          code_r;
    logic [3:0]          digit_r;
    logic                loadn_r;
    logic                key_err_r;

    logic [7:0]          cnt_inc_s;
    logic                cnt_done_s;
    logic                vec_match_s;

    keypad_sync u_sync (
        .CLK          (CLK),
        .clearn       (clearn),
        .keypad       (keypad),
        .key_vec      (key_vec_s),
        .key_valid    (key_valid_s),
        .key_released (key_released_s),
        .key_invalid  (key_invalid_s),
        .key_code     (key_code_s)
    );

    // Next counter value and the "filter satisfied" condition it implies.
    always_comb begin
        cnt_inc_s   = sat_inc(cnt_r);
        cnt_done_s  = (cnt_inc_s >= DB_COUNT);
        vec_match_s = (key_vec_s == onehot_r);
    end

    // Encoder FSM with its counter and all output registers.
    always_ff @(posedge CLK or negedge clearn) begin
        if (!clearn) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 8'd0;
            onehot_r  <= {NUM_KEYS{1'b0}};
            code_r    <= 4'd0;
            digit_r   <= 4'd0;
            loadn_r   <= 1'b1;
            key_err_r <= 1'b0;
        end else begin
            key_err_r <= key_invalid_s;
            // Strobe is high unless this edge enters LOAD.
            loadn_r   <= 1'b1;
            case (state_r)
                ST_IDLE: begin
                    cnt_r <= 8'd0;
                    if (key_valid_s && !enablen) begin
                        state_r  <= ST_DEBOUNCE;
                        onehot_r <= key_vec_s;
                        code_r   <= key_code_s;
                    end else begin
                        state_r  <= ST_IDLE;
                    end
                end
                ST_DEBOUNCE: begin
                    // A changed vector covers release, another key and multi-key.
                    if (enablen || !vec_match_s) begin
                        state_r <= ST_IDLE;
                        cnt_r   <= 8'd0;
                    end else if (cnt_done_s) begin
                        state_r <= ST_LOAD;
                        cnt_r   <= 8'd0;
                        digit_r <= code_r;
                        loadn_r <= 1'b0;
                    end else begin
                        state_r <= ST_DEBOUNCE;
                        cnt_r   <= cnt_inc_s;
                    end
                end
                ST_LOAD: begin
                    // Strobe completes regardless of enablen.
                    state_r <= ST_WAIT_RELEASE;
                    cnt_r   <= 8'd0;
                end
                ST_WAIT_RELEASE: begin
                    if (!key_released_s) begin
                        state_r <= ST_WAIT_RELEASE;
                        cnt_r   <= 8'd0;
                    end else if (cnt_done_s) begin
                        state_r <= ST_IDLE;
                        cnt_r   <= 8'd0;
                    end else begin
                        state_r <= ST_WAIT_RELEASE;
                        cnt_r   <= cnt_inc_s;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= 8'd0;
                end
            endcase
        end
    end

    assign digit   = digit_r;
    assign loadn   = loadn_r;
    assign key_err = key_err_r;

endmodule
